triple_reg_scrub: RTL and testbench

//  Parametrised TMR register, successor to the fixed triplicated register. Holds three copies of a

---
 rtl/triple_reg_scrub.sv | 110 +++++++++++
 tb/tb_triple_reg_scrub.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/triple_reg_scrub.sv
// Triplicated register with bitwise majority vote, single-copy scrubbing,
// saturating error counters, sticky uncorrectable flag and fault injection.
module triple_reg_scrub #(
   parameter int unsigned           IN_WIDTH  = 4,
   parameter int unsigned           CNT_WIDTH = 8,
   parameter bit                    SCRUB_EN  = 1'b1,
   parameter logic [IN_WIDTH-1:0]   RST_VAL   = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic [IN_WIDTH-1:0]  din_i,
   input  logic                 inj_en_i,
   input  logic [1:0]           inj_sel_i,
   input  logic [IN_WIDTH-1:0]  inj_mask_i,
   input  logic                 clr_i,
   output logic [IN_WIDTH-1:0]  dout_o,
   output logic                 error1_o,
   output logic                 error2_o,
   output logic [CNT_WIDTH-1:0] err1_cnt_o,
   output logic [CNT_WIDTH-1:0] err2_cnt_o,
   output logic                 err2_sticky_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [IN_WIDTH-1:0]  copy_q [3];
   logic [IN_WIDTH-1:0]  copy_d [3];
   logic [IN_WIDTH-1:0]  vote;
   logic                 eq01;
   logic                 eq12;
   logic                 eq02;
   logic                 any_eq;
   logic                 all_eq;
   logic                 err1;
   logic                 err2;
   logic [CNT_WIDTH-1:0] cnt1_q;
   logic [CNT_WIDTH-1:0] cnt2_q;
   logic                 sticky_q;

   assign eq01   = (copy_q[0] == copy_q[1]);
   assign eq12   = (copy_q[1] == copy_q[2]);
   assign eq02   = (copy_q[0] == copy_q[2]);
   assign any_eq = eq01 | eq12 | eq02;
   assign all_eq = eq01 & eq12;

   // two matching pairs imply the third, so "some but not all" is exactly one pair
   assign err1 = any_eq & ~all_eq;
   assign err2 = ~any_eq;

   assign vote = (copy_q[0] & copy_q[1])
               | (copy_q[1] & copy_q[2])
               | (copy_q[0] & copy_q[2]);

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         copy_d[k] = copy_q[k];
         if (we_i) begin
            copy_d[k] = din_i;
         end else if (inj_en_i && (inj_sel_i == 2'(k))) begin
            copy_d[k] = copy_q[k] ^ inj_mask_i;
         end else if (SCRUB_EN && err1) begin
            copy_d[k] = vote;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < 3; k++) begin
            copy_q[k] <= RST_VAL;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            copy_q[k] <= copy_d[k];
         end
      end
   end

   // clear wins over a same-cycle increment or sticky set
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt1_q   <= '0;
         cnt2_q   <= '0;
         sticky_q <= 1'b0;
      end else if (clr_i) begin
         cnt1_q   <= '0;
         cnt2_q   <= '0;
         sticky_q <= 1'b0;
      end else begin
         if (err1 && (cnt1_q != CNT_MAX)) begin
            cnt1_q <= cnt1_q + 1'b1;
         end
         if (err2 && (cnt2_q != CNT_MAX)) begin
            cnt2_q <= cnt2_q + 1'b1;
         end
         if (err2) begin
            sticky_q <= 1'b1;
         end
      end
   end

   assign dout_o        = vote;
   assign error1_o      = err1;
   assign error2_o      = err2;
   assign err1_cnt_o    = cnt1_q;
   assign err2_cnt_o    = cnt2_q;
   assign err2_sticky_o = sticky_q;

endmodule

// File: tb/tb_triple_reg_scrub.sv
// Directed bench: instance a uses defaults (scrub on, 8-bit counters),
// instance b has scrub off, 2-bit counters and a non-zero reset value.
module tb_triple_reg_scrub;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [3:0] din;
   logic       inj_en;
   logic [1:0] inj_sel;
   logic [3:0] inj_mask;
   logic       clr;

   logic [3:0] a_dout;
   logic       a_e1;
   logic       a_e2;
   logic [7:0] a_c1;
   logic [7:0] a_c2;
   logic       a_st;

   logic [3:0] b_dout;
   logic       b_e1;
   logic       b_e2;
   logic [1:0] b_c1;
   logic [1:0] b_c2;
   logic       b_st;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   triple_reg_scrub u_a (
      .clk_i(clk), .rst_i(rst), .we_i(we), .din_i(din),
      .inj_en_i(inj_en), .inj_sel_i(inj_sel), .inj_mask_i(inj_mask),
      .clr_i(clr), .dout_o(a_dout), .error1_o(a_e1), .error2_o(a_e2),
      .err1_cnt_o(a_c1), .err2_cnt_o(a_c2), .err2_sticky_o(a_st)
   );

   triple_reg_scrub #(
      .IN_WIDTH(4), .CNT_WIDTH(2), .SCRUB_EN(1'b0), .RST_VAL(4'h5)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .we_i(we), .din_i(din),
      .inj_en_i(inj_en), .inj_sel_i(inj_sel), .inj_mask_i(inj_mask),
      .clr_i(clr), .dout_o(b_dout), .error1_o(b_e1), .error2_o(b_e2),
      .err1_cnt_o(b_c1), .err2_cnt_o(b_c2), .err2_sticky_o(b_st)
   );

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; inj_en = 0; inj_sel = 0; inj_mask = 0; clr = 0; din = 0;
   endtask

   initial begin
      rst = 1;
      idle();
      #12;
      check("rst_a_dout", 8'(a_dout), 8'h0);
      check("rst_b_dout", 8'(b_dout), 8'h5);
      check("rst_a_e1", 8'(a_e1), 8'h0);
      check("rst_a_e2", 8'(a_e2), 8'h0);
      check("rst_a_c1", a_c1, 8'h0);
      check("rst_b_st", 8'(b_st), 8'h0);
      step();
      rst = 0;

      we = 1; din = 4'hA;
      step();
      check("wr_a_dout", 8'(a_dout), 8'hA);
      check("wr_b_dout", 8'(b_dout), 8'hA);
      check("wr_a_e1", 8'(a_e1), 8'h0);
      check("wr_b_e2", 8'(b_e2), 8'h0);
      check("wr_a_c1", a_c1, 8'h0);

      idle(); inj_en = 1; inj_sel = 1; inj_mask = 4'h1;
      step();
      check("inj_a_e1", 8'(a_e1), 8'h1);
      check("inj_a_dout", 8'(a_dout), 8'hA);
      check("inj_b_e1", 8'(b_e1), 8'h1);
      check("inj_a_c1", a_c1, 8'h0);

      idle();
      step();
      check("scrub_a_e1", 8'(a_e1), 8'h0);
      check("scrub_a_c1", a_c1, 8'h1);
      check("scrub_a_dout", 8'(a_dout), 8'hA);
      check("noscr_b_e1", 8'(b_e1), 8'h1);
      check("noscr_b_c1_1", 8'(b_c1), 8'h1);
      check("noscr_b_dout", 8'(b_dout), 8'hA);

      step();
      check("hold_a_c1", a_c1, 8'h1);
      check("noscr_b_c1_2", 8'(b_c1), 8'h2);
      step();
      check("noscr_b_c1_3", 8'(b_c1), 8'h3);
      step();
      check("sat_b_c1_a", 8'(b_c1), 8'h3);
      step();
      check("sat_b_c1_b", 8'(b_c1), 8'h3);
      check("sat_b_e1", 8'(b_e1), 8'h1);

      we = 1; din = 4'h3; inj_en = 1; inj_sel = 0; inj_mask = 4'hF;
      step();
      check("wepri_a_dout", 8'(a_dout), 8'h3);
      check("wepri_b_dout", 8'(b_dout), 8'h3);
      check("wepri_a_e1", 8'(a_e1), 8'h0);
      check("wepri_b_e1", 8'(b_e1), 8'h0);
      check("wepri_b_c1", 8'(b_c1), 8'h3);

      idle(); clr = 1;
      step();
      check("clr_a_c1", a_c1, 8'h0);
      check("clr_b_c1", 8'(b_c1), 8'h0);

      idle(); inj_en = 1; inj_sel = 0; inj_mask = 4'h1;
      step();
      check("t4a_b_e1", 8'(b_e1), 8'h1);
      check("t4a_a_c1", a_c1, 8'h0);

      inj_sel = 1; inj_mask = 4'h2;
      step();
      check("t4b_b_e2", 8'(b_e2), 8'h1);
      check("t4b_b_e1", 8'(b_e1), 8'h0);
      check("t4b_b_dout", 8'(b_dout), 8'h3);
      check("t4b_b_st", 8'(b_st), 8'h0);
      check("t4b_a_e1", 8'(a_e1), 8'h1);
      check("t4b_a_e2", 8'(a_e2), 8'h0);
      check("t4b_a_c1", a_c1, 8'h1);

      idle();
      step();
      check("t4c_b_st", 8'(b_st), 8'h1);
      check("t4c_b_c2", 8'(b_c2), 8'h1);
      check("t4c_b_e2", 8'(b_e2), 8'h1);
      check("t4c_a_e1", 8'(a_e1), 8'h0);
      check("t4c_a_c1", a_c1, 8'h2);
      check("t4c_a_st", 8'(a_st), 8'h0);

      step();
      check("t4d_b_c2", 8'(b_c2), 8'h2);

      clr = 1;
      step();
      check("clrw_b_c2", 8'(b_c2), 8'h0);
      check("clrw_b_st", 8'(b_st), 8'h0);
      check("clrw_a_c1", a_c1, 8'h0);

      idle();
      step();
      check("reset_b_st", 8'(b_st), 8'h1);
      check("reset_b_c2", 8'(b_c2), 8'h1);

      we = 1; din = 4'h6;
      step();
      check("wr6_b_dout", 8'(b_dout), 8'h6);
      check("wr6_b_e2", 8'(b_e2), 8'h0);

      idle(); inj_en = 1; inj_sel = 3; inj_mask = 4'hF;
      step();
      check("sel3_a_e1", 8'(a_e1), 8'h0);
      check("sel3_b_dout", 8'(b_dout), 8'h6);

      inj_sel = 0; inj_mask = 4'h0;
      step();
      check("mask0_b_e1", 8'(b_e1), 8'h0);

      inj_sel = 2; inj_mask = 4'h4;
      step();
      check("t6pre_a_e1", 8'(a_e1), 8'h1);
      check("t6pre_a_dout", 8'(a_dout), 8'h6);

      idle();
      #2;
      rst = 1;
      #1;
      check("t6_a_dout", 8'(a_dout), 8'h0);
      check("t6_b_dout", 8'(b_dout), 8'h5);
      check("t6_a_e1", 8'(a_e1), 8'h0);
      check("t6_b_e1", 8'(b_e1), 8'h0);
      check("t6_b_c1", 8'(b_c1), 8'h0);
      check("t6_b_st", 8'(b_st), 8'h0);
      step();
      rst = 0;
      step();
      check("post_b_dout", 8'(b_dout), 8'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
